// File: rtl/weight_row_mac.sv
// weight_row_mac
// ---------------------------------------------------------------------------
// Computes one neuron output from a row of signed 16-bit weights held in a
// dual-port ROM and a matching dual-port activation buffer. Each ISSUE cycle
// reads one even word on port A and one odd word on port B. Each word holds
// LANES weights (or activations). The block forms 2*LANES products per
// cycle, accumulates the whole row, adds the bias, shifts right by
// FRAC_BITS, applies an optional ReLU and saturates to OUT_WIDTH bits.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   start, bias            row request (sampled in IDLE) and its bias
//   addr_a, addr_b         weight ROM addresses (even / odd words)
//   q_a, q_b               weight ROM data, 1-cycle read latency
//   act_addr_a/_b          activation buffer addresses (mirror addr_a/_b)
//   act_q_a, act_q_b       activation data, 1-cycle read latency
//   busy                   row in progress until the result is accepted
//   out_valid, out_ready   result handshake
//   result                 signed saturated neuron output
// ---------------------------------------------------------------------------
module weight_row_mac #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 128,
    parameter int LANES      = 8,
    parameter int NUM_WORDS  = 16,
    parameter int LAST_LANES = 2,
    parameter int ACC_WIDTH  = 40,
    parameter int FRAC_BITS  = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int RELU       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           bias,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] q_a,
    input  logic [DATA_WIDTH-1:0] q_b,
    output logic [ADDR_WIDTH-1:0] act_addr_a,
    output logic [ADDR_WIDTH-1:0] act_addr_b,
    input  logic [DATA_WIDTH-1:0] act_q_a,
    input  logic [DATA_WIDTH-1:0] act_q_b,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  result
);

    localparam int PAIRS = NUM_WORDS / 2;
    localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(PAIRS - 1);
    // Saturation bounds expressed in the accumulator width.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                        state_r;
    state_t                        next_state_s;

    logic [ADDR_WIDTH-1:0]         k_r;
    logic [ADDR_WIDTH-1:0]         addr_a_r;
    logic [ADDR_WIDTH-1:0]         addr_b_r;
    logic signed [31:0]            bias_r;
    logic signed [ACC_WIDTH-1:0]   acc_r;
    logic                          busy_r;
    logic                          out_valid_r;
    logic [OUT_WIDTH-1:0]          result_r;

    // Pipeline qualifiers: address issued, data returned, products held.
    logic                          issue_v_r;
    logic                          issue_last_r;
    logic                          data_v_r;
    logic                          data_last_r;
    logic                          prod_v_r;
    logic                          prod_last_r;
    logic                          acc_done_r;

    logic signed [31:0]            prod_s [2*LANES];
    logic signed [31:0]            prod_r [2*LANES];
    logic signed [ACC_WIDTH-1:0]   row_sum_s;
    logic signed [ACC_WIDTH-1:0]   sum_s;
    logic signed [ACC_WIDTH-1:0]   sh_s;
    logic [OUT_WIDTH-1:0]          final_s;

    assign addr_a     = addr_a_r;
    assign addr_b     = addr_b_r;
    assign act_addr_a = addr_a_r;
    assign act_addr_b = addr_b_r;
    assign busy       = busy_r;
    assign out_valid  = out_valid_r;
    assign result     = result_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (k_r == LAST_K) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (acc_done_r) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Lane products for the returning word pair; the lanes past LAST_LANES
    // of the final (odd) word are forced to zero.
    always_comb begin
        for (int i = 0; i < 2 * LANES; i++) begin
            prod_s[i] = 32'sd0;
        end
        for (int l = 0; l < LANES; l++) begin
            logic signed [15:0] wa_v, aa_v, wb_v, ab_v;
            wa_v = q_a[DATA_WIDTH-1-16*l -: 16];
            aa_v = act_q_a[DATA_WIDTH-1-16*l -: 16];
            wb_v = q_b[DATA_WIDTH-1-16*l -: 16];
            ab_v = act_q_b[DATA_WIDTH-1-16*l -: 16];
            prod_s[l] = 32'(wa_v) * 32'(aa_v);
            if (data_last_r && (l >= LAST_LANES)) begin
                prod_s[LANES+l] = 32'sd0;
            end else begin
                prod_s[LANES+l] = 32'(wb_v) * 32'(ab_v);
            end
        end
    end

    // Product register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2 * LANES; i++) begin
                prod_r[i] <= 32'sd0;
            end
        end else if (data_v_r) begin
            for (int i = 0; i < 2 * LANES; i++) begin
                prod_r[i] <= prod_s[i];
            end
        end
    end

    // Sign-extended sum of all registered products.
    always_comb begin
        row_sum_s = '0;
        for (int i = 0; i < 2 * LANES; i++) begin
            row_sum_s = row_sum_s + ACC_WIDTH'(prod_r[i]);
        end
    end

    // Output arithmetic: bias, scale, optional ReLU, saturation.
    always_comb begin
        sum_s = acc_r + {{(ACC_WIDTH-32){bias_r[31]}}, bias_r};
        sh_s  = sum_s >>> FRAC_BITS;
        if ((RELU != 0) && sh_s[ACC_WIDTH-1]) begin
            final_s = '0;
        end else if (sh_s > SAT_MAX) begin
            final_s = SAT_MAX[OUT_WIDTH-1:0];
        end else if (sh_s < SAT_MIN) begin
            final_s = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            final_s = sh_s[OUT_WIDTH-1:0];
        end
    end

    // Control datapath: addressing, pipeline qualifiers, accumulator, result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_r          <= '0;
            addr_a_r     <= '0;
            addr_b_r     <= '0;
            bias_r       <= 32'sd0;
            acc_r        <= '0;
            busy_r       <= 1'b0;
            out_valid_r  <= 1'b0;
            result_r     <= '0;
            issue_v_r    <= 1'b0;
            issue_last_r <= 1'b0;
            data_v_r     <= 1'b0;
            data_last_r  <= 1'b0;
            prod_v_r     <= 1'b0;
            prod_last_r  <= 1'b0;
            acc_done_r   <= 1'b0;
        end else begin
            issue_v_r    <= (state_r == ST_ISSUE);
            issue_last_r <= (state_r == ST_ISSUE) && (k_r == LAST_K);
            data_v_r     <= issue_v_r;
            data_last_r  <= issue_last_r;
            prod_v_r     <= data_v_r;
            prod_last_r  <= data_last_r;
            acc_done_r   <= prod_v_r && prod_last_r;

            if (state_r == ST_ISSUE) begin
                addr_a_r <= {k_r[ADDR_WIDTH-2:0], 1'b0};
                addr_b_r <= {k_r[ADDR_WIDTH-2:0], 1'b1};
                k_r      <= k_r + 1'b1;
            end

            if ((state_r == ST_IDLE) && start) begin
                bias_r <= bias;
                acc_r  <= '0;
                k_r    <= '0;
                busy_r <= 1'b1;
            end else if (prod_v_r) begin
                acc_r <= acc_r + row_sum_s;
            end

            if ((state_r == ST_DRAIN) && acc_done_r) begin
                result_r    <= final_s;
                out_valid_r <= 1'b1;
            end else if ((state_r == ST_DONE) && out_ready) begin
                out_valid_r <= 1'b0;
                busy_r      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_weight_row_mac.sv
module tb_weight_row_mac;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [31:0]  bias;
    logic [127:0] q_a, q_b, act_q_a, act_q_b;
    logic         out_ready;
    logic [15:0]  w_val, a_val;

    logic [3:0]   addr_a0, addr_b0, act_addr_a0, act_addr_b0;
    logic [3:0]   addr_a1, addr_b1, act_addr_a1, act_addr_b1;
    logic         busy0, busy1, out_valid0, out_valid1;
    logic [15:0]  result0, result1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // ROM / activation buffer stubs: every lane carries the same value.
    always @(posedge clk) begin
        q_a     <= {8{w_val}};
        q_b     <= {8{w_val}};
        act_q_a <= {8{a_val}};
        act_q_b <= {8{a_val}};
    end

    weight_row_mac #(.RELU(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .addr_a(addr_a0), .addr_b(addr_b0), .q_a(q_a), .q_b(q_b),
        .act_addr_a(act_addr_a0), .act_addr_b(act_addr_b0),
        .act_q_a(act_q_a), .act_q_b(act_q_b),
        .busy(busy0), .out_valid(out_valid0), .out_ready(out_ready),
        .result(result0)
    );

    weight_row_mac #(.RELU(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .addr_a(addr_a1), .addr_b(addr_b1), .q_a(q_a), .q_b(q_b),
        .act_addr_a(act_addr_a1), .act_addr_b(act_addr_b1),
        .act_q_a(act_q_a), .act_q_b(act_q_b),
        .busy(busy1), .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full row: start, latency, optional address trace and hold phase,
    // result check on both ReLU variants, then the accept handshake.
    task automatic run_case(input string tag, input logic [15:0] w, input logic [15:0] a,
                            input logic [31:0] b, input logic [15:0] exp0,
                            input logic [15:0] exp1, input bit trace, input int hold);
        w_val = w;
        a_val = a;
        bias  = b;
        start = 1'b1;
        step();                     // edge E0
        start = 1'b0;
        bias  = 32'h0000_0000;
        chk({tag, "_busy_e0"}, {31'd0, busy0}, 32'd1);
        for (int i = 1; i <= 11; i++) begin
            step();
            if (trace && i <= 8) begin
                chk($sformatf("%s_addr_a_%0d", tag, i), {28'd0, addr_a0}, 32'(2 * (i - 1)));
                chk($sformatf("%s_addr_b_%0d", tag, i), {28'd0, addr_b0}, 32'(2 * (i - 1) + 1));
                chk($sformatf("%s_act_a_%0d", tag, i), {28'd0, act_addr_a0}, 32'(2 * (i - 1)));
                chk($sformatf("%s_act_b_%0d", tag, i), {28'd0, act_addr_b0}, 32'(2 * (i - 1) + 1));
            end
        end
        chk({tag, "_valid_e11"}, {31'd0, out_valid0}, 32'd0);
        step();                     // edge E12
        chk({tag, "_valid0_e12"}, {31'd0, out_valid0}, 32'd1);
        chk({tag, "_valid1_e12"}, {31'd0, out_valid1}, 32'd1);
        chk({tag, "_result_relu0"}, {16'd0, result0}, {16'd0, exp0});
        chk({tag, "_result_relu1"}, {16'd0, result1}, {16'd0, exp1});
        for (int i = 0; i < hold; i++) begin
            start = (i % 2 == 0);
            step();
            chk($sformatf("%s_hold_res_%0d", tag, i), {16'd0, result0}, {16'd0, exp0});
            chk($sformatf("%s_hold_busy_%0d", tag, i), {31'd0, busy0}, 32'd1);
            chk($sformatf("%s_hold_valid_%0d", tag, i), {31'd0, out_valid0}, 32'd1);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        step();                     // accept edge
        out_ready = 1'b0;
        chk({tag, "_valid_after"}, {31'd0, out_valid0}, 32'd0);
        chk({tag, "_busy_after"}, {31'd0, busy0}, 32'd0);
        chk({tag, "_busy1_after"}, {31'd0, busy1}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        bias      = 32'h0000_0000;
        out_ready = 1'b0;
        w_val     = 16'h0000;
        a_val     = 16'h0000;
        step();
        step();
        chk("rst_addr_a", {28'd0, addr_a0}, 32'd0);
        chk("rst_addr_b", {28'd0, addr_b0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_valid", {31'd0, out_valid0}, 32'd0);
        chk("rst_result", {16'd0, result0}, 32'd0);
        rst_n = 1'b1;
        step();

        // Masking: 122 terms of 1*256, word 15 lanes 2..7 nonzero but ignored.
        run_case("mask", 16'h0001, 16'h0100, 32'h0000_0000, 16'd122, 16'd122, 1'b0, 0);
        // Negative sum: -122 without ReLU, 0 with ReLU.
        run_case("neg", 16'hFFFF, 16'h0100, 32'h0000_0000, 16'hFF86, 16'h0000, 1'b0, 0);
        // Saturation both directions.
        run_case("satp", 16'h7FFF, 16'h7FFF, 32'h0000_0000, 16'h7FFF, 16'h7FFF, 1'b0, 0);
        run_case("satn", 16'h8000, 16'h7FFF, 32'h0000_0000, 16'h8000, 16'h0000, 1'b0, 0);
        // Bias only, with address trace.
        run_case("bias", 16'h0000, 16'h0100, 32'h0000_0A00, 16'd10, 16'd10, 1'b1, 0);
        // Consumer stalls 5 cycles with start pulses, then back-to-back row.
        run_case("hold", 16'h0001, 16'h0100, 32'h0000_0000, 16'd122, 16'd122, 1'b0, 5);
        run_case("b2b", 16'hFFFF, 16'h0100, 32'h0000_0000, 16'hFF86, 16'h0000, 1'b0, 0);

        // Reset in the middle of ISSUE.
        w_val = 16'h0001;
        a_val = 16'h0100;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy0}, 32'd0);
        chk("midrst_valid", {31'd0, out_valid0}, 32'd0);
        chk("midrst_addr_a", {28'd0, addr_a0}, 32'd0);
        chk("midrst_addr_b", {28'd0, addr_b0}, 32'd0);
        chk("midrst_result", {16'd0, result0}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        run_case("postrst", 16'h0001, 16'h0100, 32'h0000_0000, 16'd122, 16'd122, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_row_mac.md
Name: weight_row_mac

Overview:
- Multiply-accumulate engine sitting directly downstream of the dual-port weight ROM (16 x 128-bit words, 8 signed 16-bit weights per word).
- Drives both ROM read ports and a matching dual-port activation buffer, two words per cycle.
- Accumulates the full 122-term dot product, adds bias, scales, applies optional ReLU and saturates.
- Returns one neuron output to the layer sequencer over a valid/ready handshake.

Parameters:
ADDR_WIDTH, 4, weight/activation word address width
DATA_WIDTH, 128, ROM/buffer word width
LANES, 8, 16-bit lanes per word (DATA_WIDTH/16)
NUM_WORDS, 16, words per row; must be even
LAST_LANES, 2, valid lanes in final word (1..LANES)
ACC_WIDTH, 40, signed accumulator width
FRAC_BITS, 8, arithmetic right shift applied before saturation
OUT_WIDTH, 16, signed output width
RELU, 1, 1 = clamp negative results to 0

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request one row computation; sampled only in IDLE
bias  in  32  signed bias in product scale; latched when start accepted
addr_a  out  ADDR_WIDTH  weight ROM port A address (even words)
addr_b  out  ADDR_WIDTH  weight ROM port B address (odd words)
q_a  in  DATA_WIDTH  weight ROM port A data, 1-cycle latency
q_b  in  DATA_WIDTH  weight ROM port B data, 1-cycle latency
act_addr_a  out  ADDR_WIDTH  activation buffer port A address (= addr_a)
act_addr_b  out  ADDR_WIDTH  activation buffer port B address (= addr_b)
act_q_a  in  DATA_WIDTH  activation data A, 1-cycle latency
act_q_b  in  DATA_WIDTH  activation data B, 1-cycle latency
busy  out  1  high from start acceptance until output handshake completes
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  OUT_WIDTH  signed neuron output

Behaviour:
- Reset (async assert, sync release): state IDLE; all addresses 0; busy, out_valid, result, accumulator, pipeline valids 0.
- Lane order: lane 0 = bits [DATA_WIDTH-1:DATA_WIDTH-16], lane LANES-1 = bits [15:0]. All values are two's complement.
- FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE: on start=1, latch bias, clear accumulator, pair counter k=0, go to ISSUE.
- ISSUE (NUM_WORDS/2 cycles): addr_a=2k, addr_b=2k+1, act_addr mirrors them; k increments each cycle; go to DRAIN after k=NUM_WORDS/2-1.
- Pipeline:
  - P0 = address cycle.
  - P1: ROM/buffer data returns; register 2*LANES signed 32-bit products.
  - P2: sum the 16 products, sign-extend, add to accumulator.
- Masking: in word NUM_WORDS-1, lanes >= LAST_LANES contribute 0 regardless of data.
- DRAIN: wait until the final pair has been accumulated, then finalize in one cycle: sum = acc + sext(bias); sh = sum >>> FRAC_BITS; if RELU and sh<0 then 0; saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; register result; go to DONE.
- DONE: out_valid=1, result stable. Hold until out_ready=1 at a rising edge; then out_valid=0, busy=0, go to IDLE.
- out_valid is independent of out_ready; no combinational path from out_ready to any output.
- Latency: with start sampled at edge E0, out_valid rises at edge E0+12 (defaults). Accept occurs at the first edge with out_ready=1 from E0+12 on. Next start may be sampled at the edge after acceptance.
- start while busy: ignored, no queueing.
- Addresses hold their last value outside ISSUE. No reads are required outside ISSUE.
- Reset asserted mid-ISSUE/DRAIN/DONE: immediate return to reset values; partial accumulation is discarded.
- Accumulator never wraps with default parameters (122 x 2^30 < 2^39).

Test Plan:
- Stub every weight lane 0x0001, activations 0x0100, bias 0, with word-15 lanes 2..7 nonzero -> result=122 (masking honoured), out_valid rises 12 edges after start.
- Weights 0xFFFF, activations 0x0100, bias 0 -> RELU=0 gives result=-122 (0xFF86); RELU=1 gives result=0.
- Weights 0x7FFF, activations 0x7FFF -> result=0x7FFF (positive saturation). Weights 0x8000, activations 0x7FFF, RELU=0 -> result=0x8000.
- Bias 0x00000A00, weights 0 -> result=10. Address trace across 8 ISSUE cycles: addr_a=0,2,..,14; addr_b=1,3,..,15; act addresses identical.
- out_ready held low 5 cycles after out_valid: result stable and busy=1 throughout, extra start pulses ignored. Raise out_ready: one accept, then a back-to-back start gives a correct second result.
- Assert rst_n low in ISSUE cycle 4: all outputs 0, state IDLE. After release, a new start with case-1 data -> result=122 (no residue).
